alu_result_buffer: RTL and testbench

//  Execute-stage output buffer sitting directly downstream of the ALU result mux.

---
 rtl/alu_result_buffer.sv | 80 ++++++++
 tb/tb_alu_result_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Execute-stage result buffer: captures ALU result/carry/overflow/rd, derives NZCV,
// and hands entries to writeback through a 2-entry valid/ready FIFO with synchronous flush.
module alu_result_buffer #(
    parameter int N     = 4,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic [REG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [3:0]       out_flags,
    output logic [REG_W-1:0] out_rd
);

    typedef struct packed {
        logic [N-1:0]     result;
        logic [3:0]       flags;
        logic [REG_W-1:0] rd;
    } entry_t;

    entry_t     slot [2];
    entry_t     in_ent;
    logic [1:0] count;
    logic       head;
    logic       tail;
    logic       push;
    logic       pop;

    always_comb begin
        in_ent.result = in_result;
        in_ent.flags  = {in_result[N-1], (in_result == '0), in_carry, in_overflow};
        in_ent.rd     = in_rd;
    end

    // Handshake readiness depends only on registered count, so no in->out comb path.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            head    <= 1'b0;
            tail    <= 1'b0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else if (flush) begin
            // Slot contents stay; only the valid accounting is killed.
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                slot[tail] <= in_ent;
                tail       <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_result = slot[head].result;
    assign out_flags  = slot[head].flags;
    assign out_rd     = slot[head].rd;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: vector table for single/fill/simultaneous/flush,
// then a scoreboarded wrap stream and an asynchronous mid-stream reset.
module tb_alu_result_buffer;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_carry;
    logic       in_overflow;
    logic [3:0] in_rd;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] out_rd;

    int n_cmp = 0;
    int n_err = 0;

    alu_result_buffer #(.N(4), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_carry(in_carry), .in_overflow(in_overflow), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] res;
        logic       c;
        logic       v;
        logic [3:0] rd;
        logic       ordy;
        logic       fl;
        logic       e_ov;
        logic       e_ir;
        logic       chkd;
        logic [3:0] e_res;
        logic [3:0] e_fl;
        logic [3:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [3:0] res, input logic c,
                                input logic v, input logic [3:0] rd, input logic ordy,
                                input logic fl, input logic e_ov, input logic e_ir,
                                input logic chkd, input logic [3:0] e_res,
                                input logic [3:0] e_fl, input logic [3:0] e_rd);
        vec_t t;
        t.iv = iv; t.res = res; t.c = c; t.v = v; t.rd = rd; t.ordy = ordy; t.fl = fl;
        t.e_ov = e_ov; t.e_ir = e_ir; t.chkd = chkd;
        t.e_res = e_res; t.e_fl = e_fl; t.e_rd = e_rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] res, input logic c, input logic v,
                         input logic [3:0] rd, input logic ordy, input logic fl);
        in_valid = iv; in_result = res; in_carry = c; in_overflow = v;
        in_rd = rd; out_ready = ordy; flush = fl;
    endtask

    function automatic logic [3:0] nzcv(input logic [3:0] r, input logic c, input logic v);
        return {r[3], (r == 4'h0), c, v};
    endfunction

    vec_t vt [15];

    initial begin
        logic [3:0] sres [6];
        logic [3:0] srd  [6];
        logic       sc   [6];
        logic       sv   [6];
        int sent;
        int recv;
        int cyc;

        // Expected values describe the state just after the clock edge.
        //        iv res   c  v  rd    ordy fl  ov ir chk res   flags    rd
        vt[0]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0,  0, 1, 1, 4'h0, 4'b0000, 4'h0);
        vt[1]  = mk(1, 4'h0, 1, 0, 4'h3, 1, 0,  1, 1, 1, 4'h0, 4'b0110, 4'h3);
        vt[2]  = mk(0, 4'h0, 0, 0, 4'h0, 1, 0,  0, 1, 0, 4'h0, 4'b0000, 4'h0);
        vt[3]  = mk(1, 4'h8, 0, 0, 4'h5, 0, 0,  1, 1, 1, 4'h8, 4'b1000, 4'h5);
        vt[4]  = mk(1, 4'h5, 0, 0, 4'h6, 0, 0,  1, 0, 1, 4'h8, 4'b1000, 4'h5);
        vt[5]  = mk(1, 4'h1, 0, 0, 4'h7, 0, 0,  1, 0, 1, 4'h8, 4'b1000, 4'h5);
        vt[6]  = mk(0, 4'h0, 0, 0, 4'h0, 1, 0,  1, 1, 1, 4'h5, 4'b0000, 4'h6);
        vt[7]  = mk(1, 4'hF, 0, 0, 4'h9, 1, 0,  1, 1, 1, 4'hF, 4'b1000, 4'h9);
        vt[8]  = mk(1, 4'h3, 1, 1, 4'h2, 0, 0,  1, 0, 1, 4'hF, 4'b1000, 4'h9);
        vt[9]  = mk(1, 4'h7, 0, 0, 4'h4, 1, 1,  0, 1, 0, 4'h0, 4'b0000, 4'h0);
        vt[10] = mk(1, 4'h7, 0, 0, 4'h4, 0, 1,  0, 1, 0, 4'h0, 4'b0000, 4'h0);
        vt[11] = mk(0, 4'h0, 0, 0, 4'h0, 0, 0,  0, 1, 0, 4'h0, 4'b0000, 4'h0);
        vt[12] = mk(1, 4'hA, 0, 1, 4'h1, 0, 0,  1, 1, 1, 4'hA, 4'b1001, 4'h1);
        vt[13] = mk(0, 4'h0, 0, 0, 4'h0, 1, 1,  0, 1, 0, 4'h0, 4'b0000, 4'h0);
        vt[14] = mk(0, 4'h0, 0, 0, 4'h0, 1, 0,  0, 1, 0, 4'h0, 4'b0000, 4'h0);

        rst_n = 1'b0;
        drive(0, 4'h0, 0, 0, 4'h0, 0, 0);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].iv, vt[i].res, vt[i].c, vt[i].v, vt[i].rd, vt[i].ordy, vt[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ir);
            if (vt[i].chkd) begin
                chk($sformatf("v%0d_out_result", i), out_result, vt[i].e_res);
                chk($sformatf("v%0d_out_flags", i), out_flags, vt[i].e_fl);
                chk($sformatf("v%0d_out_rd", i), out_rd, vt[i].e_rd);
            end
        end

        // Wrap stream: 6 back-to-back pushes, out_ready toggling every cycle.
        sres = '{4'h0, 4'h9, 4'h6, 4'hF, 4'h2, 4'hC};
        srd  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        sc   = '{1, 0, 1, 0, 0, 1};
        sv   = '{0, 1, 0, 0, 1, 1};
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 6 && cyc < 60) begin
            if (sent < 6)
                drive(1, sres[sent], sc[sent], sv[sent], srd[sent], cyc[0], 0);
            else
                drive(0, 4'h0, 0, 0, 4'h0, cyc[0], 0);
            #1;
            if (out_valid && out_ready) begin
                chk($sformatf("wrap%0d_result", recv), out_result, sres[recv]);
                chk($sformatf("wrap%0d_flags", recv), out_flags, nzcv(sres[recv], sc[recv], sv[recv]));
                chk($sformatf("wrap%0d_rd", recv), out_rd, srd[recv]);
                recv++;
            end
            if (in_valid && in_ready)
                sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("wrap_received", recv, 6);
        chk("wrap_drained", out_valid, 0);

        // Fill to 2 entries, then assert reset between edges.
        drive(1, 4'h7, 1, 1, 4'hE, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 4'hB, 0, 1, 4'hD, 0, 0);
        @(posedge clk);
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        drive(0, 4'h0, 0, 0, 4'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_result", out_result, 0);
        chk("async_rst_out_flags", out_flags, 0);
        chk("async_rst_out_rd", out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
